fp_mul_rr_sched: RTL and testbench

- Round-robin scheduler sharing one combinational single-precision fp multiplier among NREQ requesters.
- Accepts operand pairs through per-requester valid/ready handshakes and issues at most one operation per cycle into a registered operand stage that drives the shared multiplier.
- Captures the product one cycle later into a per-requester result slot, returned through a valid/ready handshake.
- Sits between the vector/scalar FP clients and the fp multiplier datapath. It is the only block that drives the multiplier's inputs.

---
 rtl/fp_mul_rr_sched.sv | 141 ++++++++++++++
 tb/tb_fp_mul_rr_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_rr_sched.sv
// Round-robin scheduler that time-shares one combinational fp multiplier among NREQ requesters.
// Operands are registered into a single issue stage; the product is captured one cycle later into a per-requester slot.
module fp_mul_rr_sched #(
    parameter int NREQ = 4,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic [31:0]          mul_y,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [32*NREQ-1:0]   rsp_y,
    output logic [CNTW-1:0]      op_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]              ptr_q, ptr_d;
    logic [PW-1:0]              tag_q, tag_d;
    logic                       stg_vld_q, stg_vld_d;
    logic [31:0]                mul_a_q, mul_a_d;
    logic [31:0]                mul_b_q, mul_b_d;
    logic [NREQ-1:0]            rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0][31:0]      rsp_y_q, rsp_y_d;
    logic [CNTW-1:0]            cnt_q, cnt_d;

    logic [NREQ-1:0]            pend_s;
    logic [NREQ-1:0]            elig_s;
    logic [NREQ-1:0]            grant_s;
    logic [PW-1:0]              gnt_idx_s;
    logic                       gnt_any_s;
    logic [PW-1:0]              idx_s;

    // One outstanding op per requester: blocked while in the issue stage or while its slot is unread.
    always_comb begin
        pend_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend_s[i] = (stg_vld_q && (int'(tag_q) == i)) || rsp_valid_q[i];
        end
        elig_s = req_valid & ~pend_s;
    end

    // Scan from the pointer and take the first eligible requester.
    always_comb begin
        grant_s   = '0;
        gnt_idx_s = '0;
        gnt_any_s = 1'b0;
        idx_s     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = PW'((int'(ptr_q) + k) % NREQ);
            if (!gnt_any_s && elig_s[idx_s]) begin
                gnt_any_s        = 1'b1;
                gnt_idx_s        = idx_s;
                grant_s[idx_s]   = 1'b1;
            end else begin
                gnt_any_s        = gnt_any_s;
            end
        end
    end

    // Next-state: slot release, product capture, then issue of the new grant.
    always_comb begin
        ptr_d       = ptr_q;
        tag_d       = tag_q;
        stg_vld_d   = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        cnt_d       = cnt_q;

        for (int i = 0; i < NREQ; i++) begin
            if (rsp_valid_q[i] && rsp_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
            end else begin
                rsp_valid_d[i] = rsp_valid_q[i];
            end
        end

        // Capture and release never hit the same slot: pend keeps a full slot from being issued.
        if (stg_vld_q) begin
            rsp_valid_d[tag_q] = 1'b1;
            rsp_y_d[tag_q]     = mul_y;
        end else begin
            rsp_y_d            = rsp_y_q;
        end

        // Operands hold on idle cycles so the multiplier inputs do not toggle.
        if (gnt_any_s) begin
            mul_a_d   = req_a[int'(gnt_idx_s)*32 +: 32];
            mul_b_d   = req_b[int'(gnt_idx_s)*32 +: 32];
            tag_d     = gnt_idx_s;
            stg_vld_d = 1'b1;
            cnt_d     = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
            if (int'(gnt_idx_s) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_s + {{(PW-1){1'b0}}, 1'b1};
            end
        end else begin
            stg_vld_d = 1'b0;
        end
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            tag_q       <= '0;
            stg_vld_q   <= 1'b0;
            mul_a_q     <= 32'h0000_0000;
            mul_b_q     <= 32'h0000_0000;
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
            cnt_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            tag_q       <= tag_d;
            stg_vld_q   <= stg_vld_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = grant_s;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_fp_mul_rr_sched.sv
// Randomized self-checking bench for fp_mul_rr_sched against a per-requester state model.
module tb_fp_mul_rr_sched;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [32*N-1:0] req_a, req_b, rsp_y;
    logic [31:0]  mul_a, mul_b, mul_y;
    logic [15:0]  op_count;

    logic [1:0]   v4, rdy4, rv4, rr4;
    logic [63:0]  a4, b4, ry4;
    logic [31:0]  ma4, mb4, my4;
    logic [3:0]   cnt4;

    int errors = 0;
    int checks = 0;

    // model state
    int          m_ptr;
    int          m_tag;
    bit          m_full [N];
    logic [31:0] m_val  [N];
    logic [31:0] m_ma, m_mb;
    int          m_cnt;
    int          last_grant;

    always #5 clk = ~clk;

    // Reference multiplier for normal operands (truncating).
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        logic        s;
        int          e;
        s = a[31] ^ b[31];
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        if (e <= 0) return {s, 31'd0};
        if (e >= 255) return {s, 8'hFF, 23'd0};
        return {s, e[7:0], m};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r;
        logic [7:0]  ex;
        r  = $urandom;
        ex = 8'($urandom_range(190, 64));
        return {r[31], ex, r[22:0]};
    endfunction

    assign mul_y = fmul(mul_a, mul_b);
    assign my4   = fmul(ma4, mb4);

    fp_mul_rr_sched #(.NREQ(N), .CNTW(16)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .op_count(op_count)
    );

    fp_mul_rr_sched #(.NREQ(2), .CNTW(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .req_valid(v4), .req_ready(rdy4),
        .req_a(a4), .req_b(b4),
        .mul_a(ma4), .mul_b(mb4), .mul_y(my4),
        .rsp_valid(rv4), .rsp_ready(rr4), .rsp_y(ry4),
        .op_count(cnt4)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_tag = -1;
        m_ma  = 32'd0;
        m_mb  = 32'd0;
        m_cnt = 0;
        for (int i = 0; i < N; i++) begin
            m_full[i] = 1'b0;
            m_val[i]  = 32'd0;
        end
    endtask

    // Drive one cycle of inputs, check against the model, then advance the model across the edge.
    task automatic drive_cycle(input logic [N-1:0] v, input logic [N-1:0] rr,
                               input bit fixed, input logic [31:0] fa, input logic [31:0] fb);
        logic [N-1:0]    exp_rv;
        logic [32*N-1:0] exp_y;
        logic [N-1:0]    exp_rdy;
        int              g;
        int              idx;
        @(negedge clk);
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = fixed ? fa : rnd_fp();
            req_b[i*32 +: 32] = fixed ? fb : rnd_fp();
        end
        #1;
        for (int i = 0; i < N; i++) begin
            exp_rv[i]         = m_full[i];
            exp_y[i*32 +: 32] = m_val[i];
        end
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("rsp_y", rsp_y, exp_y);
        chk("mul_a", mul_a, m_ma);
        chk("mul_b", mul_b, m_mb);
        chk("op_count", op_count, 16'(m_cnt));
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && v[idx] && m_tag != idx && !m_full[idx]) g = idx;
        end
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", req_ready, exp_rdy);
        last_grant = g;
        for (int i = 0; i < N; i++) begin
            if (m_full[i] && rr[i]) m_full[i] = 1'b0;
        end
        if (m_tag >= 0) begin
            m_full[m_tag] = 1'b1;
            m_val[m_tag]  = fmul(m_ma, m_mb);
        end
        if (g >= 0) begin
            m_ma  = req_a[g*32 +: 32];
            m_mb  = req_b[g*32 +: 32];
            m_tag = g;
            m_ptr = (g + 1) % N;
            m_cnt = m_cnt + 1;
        end else begin
            m_tag = -1;
        end
    endtask

    initial begin
        int          n1;
        logic [31:0] la, lb;
        rst = 1'b1;
        req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
        v4 = 2'b00; rr4 = 2'b11; a4 = 64'd0; b4 = 64'd0;
        last_grant = -1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 4'b0000);
        chk("reset_op_count", op_count, 16'd0);
        chk("reset_mul_a", mul_a, 32'd0);
        rst = 1'b0;

        // single op
        drive_cycle(4'b0001, 4'b0000, 1'b1, 32'h3FC0_0000, 32'h3FA0_0000);
        chk("single_ready", req_ready, 4'b0001);
        drive_cycle(4'b0000, 4'b0000, 1'b0, 32'd0, 32'd0);
        chk("single_mul_a", mul_a, 32'h3FC0_0000);
        drive_cycle(4'b0000, 4'b0001, 1'b0, 32'd0, 32'd0);
        chk("single_rsp_valid0", rsp_valid[0], 1'b1);
        chk("single_rsp_y0", rsp_y[31:0], 32'h3FF0_0000);
        chk("single_op_count", op_count, 16'd1);

        // pointer hold
        drive_cycle(4'b0100, 4'b1111, 1'b0, 32'd0, 32'd0);
        repeat (3) drive_cycle(4'b0000, 4'b1111, 1'b0, 32'd0, 32'd0);
        drive_cycle(4'b1111, 4'b1111, 1'b0, 32'd0, 32'd0);
        chk("ptr_hold", req_ready, 4'b1000);

        // round robin, all valid, immediate consumption
        repeat (24) drive_cycle(4'b1111, 4'b1111, 1'b0, 32'd0, 32'd0);

        // reset mid-flight
        drive_cycle(4'b0010, 4'b1111, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        req_valid = '0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 4'b0000);
        chk("midrst_op_count", op_count, 16'd0);
        chk("midrst_mul_a", mul_a, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(4'b0000, 4'b1111, 1'b0, 32'd0, 32'd0);
        drive_cycle(4'b1111, 4'b1111, 1'b0, 32'd0, 32'd0);
        chk("midrst_first_grant", req_ready, 4'b0001);
        repeat (6) drive_cycle(4'b0000, 4'b1111, 1'b0, 32'd0, 32'd0);

        // backpressure on requester 1
        n1 = 0;
        for (int c = 0; c < 12; c++) begin
            drive_cycle(4'b0011, 4'b1101, 1'b0, 32'd0, 32'd0);
            if (req_ready[1]) n1++;
        end
        chk("bp_r1_grants", 32'(n1), 32'd1);
        drive_cycle(4'b0011, 4'b1111, 1'b0, 32'd0, 32'd0);
        repeat (6) drive_cycle(4'b0011, 4'b1101, 1'b0, 32'd0, 32'd0);
        repeat (4) drive_cycle(4'b0000, 4'b1111, 1'b0, 32'd0, 32'd0);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            drive_cycle(N'($urandom), N'($urandom), 1'b0, 32'd0, 32'd0);
        end

        // counter wrap on the CNTW=4 instance
        la = 32'd0; lb = 32'd0;
        for (int p = 0; p < 17; p++) begin
            @(negedge clk);
            la = rnd_fp(); lb = rnd_fp();
            a4 = {32'd0, la}; b4 = {32'd0, lb};
            v4 = 2'b01;
            @(negedge clk);
            v4 = 2'b00;
            repeat (2) @(negedge clk);
            if (p == 15) chk("wrap_at_16", cnt4, 4'd0);
        end
        chk("wrap_17", cnt4, 4'd1);
        chk("wrap_last_y", ry4[31:0], fmul(la, lb));
        chk("wrap_released", rv4, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
